vault_door_ctrl: RTL

Downstream stage of the vault puzzle core. It consumes all_done, alarm and time_lock_out and drives the physical door bolt and the siren. It enforces confirmed unlocks, a timed open window and a relock handshake with the door sensor. It also counts alarm strikes, enforcing a timed lockout per strike and a terminal lockdown after MAX_STRIKES.

---
 rtl/vault_pkg.sv | 17 +
 rtl/vault_door_ctrl_timer.sv | 27 ++
 rtl/vault_door_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vault_pkg.sv
// Shared definitions for the vault door controller: state encodings and time-lock release code.
// The encodings are fixed because state_out exposes them to debug tooling.
package vault_pkg;

  typedef enum logic [2:0] {
    ARMED    = 3'd0,
    VERIFY   = 3'd1,
    OPEN     = 3'd2,
    RELOCK   = 3'd3,
    ALARM    = 3'd4,
    LOCKOUT  = 3'd5,
    TERMINAL = 3'd6
  } state_t;

  localparam logic [1:0] TL_RELEASED = 2'b11;

endpackage

// File: rtl/vault_door_ctrl_timer.sv
// Loadable down-counter shared by all timed states; load wins over count, counting stops at zero.
// Zero flag is combinational from the registered value, so it is valid the cycle after a load.
module vault_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  assign zero = (value == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && !zero) begin
      value <= value - CNT_W'(1);
    end
  end

endmodule

// File: rtl/vault_door_ctrl.sv
// Door bolt / siren sequencer behind the puzzle core: confirmed unlock, timed open, relock handshake,
// strike counting with timed lockout and terminal lockdown. Moore outputs; puzzle_rst is registered.
module vault_door_ctrl
  import vault_pkg::*;
#(
  parameter int CONFIRM_CYCLES = 2,
  parameter int OPEN_CYCLES    = 50,
  parameter int SIREN_CYCLES   = 20,
  parameter int LOCKOUT_CYCLES = 100,
  parameter int MAX_STRIKES    = 3,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       all_done,
  input  logic       alarm,
  input  logic [1:0] time_lock_out,
  input  logic       door_closed,
  output logic       bolt_retract,
  output logic       siren,
  output logic       lockdown,
  output logic       puzzle_rst,
  output logic [1:0] strike_count,
  output logic [2:0] state_out
);

  localparam logic [CNT_W-1:0] CONFIRM_M1 = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [CNT_W-1:0] OPEN_M1    = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIREN_M1   = CNT_W'(SIREN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_M1 = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]       STRIKE_MAX = 2'(MAX_STRIKES);

  state_t           state, next_state;
  logic             alarm_q;
  logic             alarm_rise;
  logic             unlock_ok;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;

  assign unlock_ok  = all_done && (time_lock_out == TL_RELEASED);
  assign alarm_rise = alarm && !alarm_q;

  // Every state change reloads the timer with the new state's duration minus one.
  assign tmr_load = (next_state != state);

  always_comb begin
    tmr_load_val = '0;
    case (next_state)
      VERIFY:  tmr_load_val = CONFIRM_M1;
      OPEN:    tmr_load_val = OPEN_M1;
      ALARM:   tmr_load_val = SIREN_M1;
      LOCKOUT: tmr_load_val = LOCKOUT_M1;
      default: tmr_load_val = '0;
    endcase
  end

  vault_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (1'b1),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARMED;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ARMED: begin
        if (alarm_rise)     next_state = ALARM;
        else if (unlock_ok) next_state = VERIFY;
      end
      VERIFY: begin
        if (alarm_rise)      next_state = ALARM;
        else if (!unlock_ok) next_state = ARMED;
        else if (tmr_zero)   next_state = OPEN;
      end
      OPEN:     if (tmr_zero)    next_state = RELOCK;
      RELOCK:   if (door_closed) next_state = ARMED;
      ALARM: begin
        if (tmr_zero) next_state = (strike_count == STRIKE_MAX) ? TERMINAL : LOCKOUT;
      end
      LOCKOUT:  if (tmr_zero)    next_state = ARMED;
      TERMINAL: next_state = TERMINAL;
      default:  next_state = TERMINAL;
    endcase
  end

  always_comb begin
    bolt_retract = 1'b0;
    siren        = 1'b0;
    lockdown     = 1'b0;
    state_out    = state;
    case (state)
      OPEN, RELOCK: bolt_retract = 1'b1;
      ALARM:        siren        = 1'b1;
      LOCKOUT:      lockdown     = 1'b1;
      ARMED, VERIFY: ;
      default: begin
        siren    = 1'b1;
        lockdown = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_q      <= 1'b0;
      puzzle_rst   <= 1'b0;
      strike_count <= '0;
    end else begin
      alarm_q    <= alarm;
      puzzle_rst <= ((state == RELOCK) || (state == LOCKOUT)) && (next_state == ARMED);
      if ((state == VERIFY) && (next_state == OPEN)) begin
        strike_count <= '0;
      end else if ((state != ALARM) && (next_state == ALARM) && (strike_count != STRIKE_MAX)) begin
        strike_count <= strike_count + 2'd1;
      end
    end
  end

endmodule
